// File: rtl/operand_bypass_ctrl_pkg.sv
// Shared definitions for the execute-stage operand bypass controller:
// mux select encodings, the in-flight tracker entry and the select priority.
package operand_bypass_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // Operand mux select encodings
  localparam logic [1:0] SEL_RF  = 2'b00;  // register file read data
  localparam logic [1:0] SEL_MEM = 2'b01;  // M-stage ALU result
  localparam logic [1:0] SEL_WB  = 2'b10;  // W-stage writeback data
  localparam logic [1:0] SEL_WB1 = 2'b11;  // W+1 holding latch

  // One in-flight destination being tracked down the pipe
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } trk_entry_t;

  // Source select for one operand, judged from where the producers will sit
  // once the consumer advances into X: X->M (01), M->W (10), W->W+1 (11).
  // The youngest matching producer wins. A W1 match is already in the
  // register file, so it deliberately resolves to the regfile path.
  function automatic logic [1:0] bypass_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input trk_entry_t            x,
    input trk_entry_t            m,
    input trk_entry_t            w,
    input trk_entry_t            w1
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (rs == ZERO_REG)                sel = SEL_RF;
    else if (x.valid  && x.rd  == rs)  sel = SEL_MEM;
    else if (m.valid  && m.rd  == rs)  sel = SEL_WB;
    else if (w.valid  && w.rd  == rs)  sel = SEL_WB1;
    else if (w1.valid && w1.rd == rs)  sel = SEL_RF;
    return sel;
  endfunction

endpackage

// File: rtl/bypass_stage_reg.sv
// One tracker entry of the bypass pipeline. Captures the upstream entry when
// load is high, otherwise inserts a bubble (all-zero, i.e. invalid).
module bypass_stage_reg
  import operand_bypass_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  trk_entry_t d,
  output trk_entry_t q
);

  // Advance the entry every cycle: capture upstream or become a bubble
  // NOTE: state is written with <= so every stage samples its neighbour's
  // pre-edge value; blocking assignments here would collapse the chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
    else           q <= '0;
  end

endmodule

// File: rtl/operand_bypass_ctrl.sv
// Execute-stage operand bypass controller. Tracks in-flight destinations
// through X/M/W/W1, produces registered 4:1 mux selects for operands A and B
// and a combinational load-use stall back to fetch/decode.
module operand_bypass_ctrl
  import operand_bypass_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs_a,
  input  logic [REG_ADDR_W-1:0] dec_rs_b,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_we,
  input  logic                  dec_is_load,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            sel_a,
  output logic [1:0]            sel_b,
  output logic                  sel_valid
);

  trk_entry_t dec_entry;
  trk_entry_t x_q, m_q, w_q, w1_q;
  logic       hit_a, hit_b;
  logic       x_load;
  logic [1:0] sel_a_d, sel_b_d;

  // Decode-side hazard detection and next-cycle select computation
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    dec_entry         = '0;
    dec_entry.valid   = dec_we && (dec_rd != ZERO_REG);
    dec_entry.rd      = dec_rd;
    dec_entry.is_load = dec_is_load;

    hit_a = (dec_rs_a != ZERO_REG) && x_q.valid && (x_q.rd == dec_rs_a);
    hit_b = (dec_rs_b != ZERO_REG) && x_q.valid && (x_q.rd == dec_rs_b);

    // A load in X has no data until W, one cycle too late for the consumer.
    // Flush wins over stall; reset forces the stall low immediately.
    stall = dec_valid && !flush && !reset && x_q.is_load && (hit_a || hit_b);

    // X takes the decoded instruction only when it really advances
    x_load = dec_valid && !stall && !flush;

    sel_a_d = bypass_sel(dec_rs_a, x_q, m_q, w_q, w1_q);
    sel_b_d = bypass_sel(dec_rs_b, x_q, m_q, w_q, w1_q);
  end

  // Tracker chain: decode -> X -> M -> W -> W1; older stages always advance
  bypass_stage_reg u_stage_x (
    .clock (clock),
    .reset (reset),
    .load  (x_load),
    .d     (dec_entry),
    .q     (x_q)
  );

  bypass_stage_reg u_stage_m (
    .clock (clock),
    .reset (reset),
    .load  (1'b1),
    .d     (x_q),
    .q     (m_q)
  );

  bypass_stage_reg u_stage_w (
    .clock (clock),
    .reset (reset),
    .load  (1'b1),
    .d     (m_q),
    .q     (w_q)
  );

  bypass_stage_reg u_stage_w1 (
    .clock (clock),
    .reset (reset),
    .load  (1'b1),
    .d     (w_q),
    .q     (w1_q)
  );

  // Register selects so they are stable while the consumer occupies X
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_a     <= SEL_RF;
      sel_b     <= SEL_RF;
      sel_valid <= 1'b0;
    end else if (stall || flush) begin
      sel_a     <= SEL_RF;
      sel_b     <= SEL_RF;
      sel_valid <= 1'b0;
    end else begin
      sel_a     <= sel_a_d;
      sel_b     <= sel_b_d;
      sel_valid <= dec_valid;
    end
  end

endmodule
